tbu_sched: RTL and testbench
============================

Name: tbu_sched

Overview:
- Survivor-memory controller and traceback scheduler for the Viterbi decoder.
- Accepts one 8-bit ACS decision vector per handshake and stores it in a 4-bank circular survivor memory, TB_LEN entries per bank.
- Sequences the traceback unit: a trace pass over the newest full bank (selection=0), then a decode pass over the oldest bank (selection=1).
- Collects the reversed decoded bits and emits them in forward time order on a valid/ready stream.

Parameters:
- TB_LEN, 8: entries per bank (traceback depth). Power of 2, at least 2. AW = $clog2(TB_LEN).
- NUM_BANKS, 4: fixed. Taken from the package; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- dec_in  in  8  ACS decision vector; bit s = survivor decision of trellis state s
- dec_valid  in  1  dec_in valid
- dec_ready  out  1  decision write accepted this cycle when dec_valid && dec_ready
- tbu_enable  out  1  to TBU enable
- tbu_selection  out  1  to TBU selection: 0 = trace, 1 = decode
- tbu_d_in_0  out  8  trace-pass decision word; 0 when selection=1
- tbu_d_in_1  out  8  decode-pass decision word; 0 when selection=0
- tbu_d_o  in  1  TBU decoded bit, registered in the TBU
- tbu_wr_en  in  1  TBU bit-valid, registered in the TBU
- out_bit  out  1  decoded bit, forward time order
- out_valid  out  1  out_bit valid
- out_ready  in  1  downstream accept
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: all outputs 0 except dec_ready=1. wr_bank=0, wr_addr=0, rd_base=0, full_cnt=0, output buffer empty, FSM=IDLE.
- Write side:
  - On dec_valid && dec_ready, bank[wr_bank][wr_addr] <= dec_in and wr_addr increments.
  - When wr_addr wraps from TB_LEN-1 to 0, wr_bank increments mod 4 and full_cnt increments.
  - dec_ready = (full_cnt != 4).
  - Invariant: wr_bank == (rd_base + full_cnt) mod 4.
- Session start: leave IDLE when full_cnt >= 2 and the output buffer is empty. trace bank T = rd_base+1 mod 4; decode bank D = rd_base.
- FSM states:
  - IDLE: enable=0, which forces the TBU state register to 0.
  - TRACE: TB_LEN cycles. enable=1, selection=0. rd_addr counts TB_LEN-1 down to 0. tbu_d_in_0 = bank[T][rd_addr], combinational from registered rd_addr.
  - DECODE: TB_LEN cycles. enable=1, selection=1. rd_addr counts TB_LEN-1 down to 0. tbu_d_in_1 = bank[D][rd_addr]. No enable drop between TRACE and DECODE, so the TBU state carries over.
  - TAIL: 1 cycle. enable=0, selection=0. Captures the final TBU output.
  - At the end of TAIL: rd_base++, full_cnt--, then IDLE.
- Simultaneous bank completion and bank release in one cycle: full_cnt unchanged.
- Capture:
  - The TBU output lags by 1 cycle, so tbu_wr_en is high from DECODE cycle 2 through TAIL.
  - The k-th captured bit (k = 0..TB_LEN-1) is written to buf[TB_LEN-1-k]. A capture counter tracks k.
  - tbu_wr_en seen outside DECODE/TAIL is ignored.
- Drain:
  - After TAIL, the buffer is marked full and out_valid=1 with out_bit=buf[0].
  - Each out_valid && out_ready advances the index. After buf[TB_LEN-1] is accepted, the buffer is empty and out_valid=0 on the next cycle.
  - out_bit is stable while out_valid && !out_ready.
- Latency: first out_valid is 2*TB_LEN+2 cycles after the cycle in which the second bank completes, with the buffer empty and a 1-cycle IDLE decision.
- Hazards:
  - Bank wr_bank is never T or D during a session, because full_cnt >= 2 holds throughout.
  - Writes continue during sessions.
- Reset mid-operation: asynchronous return to reset values. Partial banks and buffer contents are discarded, and tbu_enable=0 immediately.

Decomposition:
- Package tbu_sched_pkg holds:
  - NUM_BANKS=4
  - N_TRELLIS=8
  - typedef dec_word_t (logic [7:0])
  - enum sched_state_t {IDLE, TRACE, DECODE, TAIL}
- One sub-module, tbu_reorder_buf: TB_LEN-bit reversal buffer with capture port (wr, bit, index) and drain port (valid/ready). It owns the empty/full flag and the drain index.

Test Plan:
- Write 16 words of 8'hFF, out_ready=1 -> exactly one session, 8 out_bit=1, dec_ready stays 1, final full_cnt=1.
- Write 16 words of 8'h00 -> 8 out_bit=0. tbu_d_in_1 is 0 during TRACE and tbu_d_in_0 is 0 during DECODE.
- Write bank0 = {8'h00 x7, 8'h01 at addr7} and bank1 = all 8'h00 -> output sequence 0,0,0,0,0,0,0,1.
- Hold out_ready=0 and stream 48 valid words -> dec_ready falls after the 32nd accept, with one buffered session pending. Release out_ready -> 8 bits drained, then the next session starts and dec_ready recovers after its TAIL.
- Assert rst low during DECODE cycle 3 -> all outputs reach reset values asynchronously. After release, the 16-word 8'hFF test passes again.
- Single-word stimulus: dec_valid pulsed every 3rd cycle -> same bit results as back-to-back writes. Sessions never overlap, and tbu_enable drops for at least 1 cycle (TAIL) between sessions.

Source files
------------

// File: rtl/tbu_sched_pkg.sv
// ---------------------------------------------------------------------------
// tbu_sched_pkg
// Shared constants and types for the Viterbi survivor-memory controller and
// traceback scheduler.
//   NUM_BANKS     : survivor memory banks (fixed, not a module parameter)
//   N_TRELLIS     : trellis states, i.e. the width of one ACS decision vector
//   dec_word_t    : one ACS decision vector, bit s = decision of state s
//   sched_state_t : traceback session phases
// ---------------------------------------------------------------------------
package tbu_sched_pkg;

   localparam int NUM_BANKS = 4;
   localparam int N_TRELLIS = 8;

   typedef logic [N_TRELLIS-1:0] dec_word_t;

   typedef enum logic [1:0] {
      IDLE,
      TRACE,
      DECODE,
      TAIL
   } sched_state_t;

endpackage : tbu_sched_pkg

// File: rtl/tbu_sched_if.sv
// ---------------------------------------------------------------------------
// tbu_sched_if
// Every handshake/bus signal of the traceback scheduler in one bundle.
//   Decision stream : dec_in, dec_valid, dec_ready
//   TBU control     : tbu_enable, tbu_selection, tbu_d_in_0, tbu_d_in_1
//   TBU result      : tbu_d_o, tbu_wr_en
//   Decoded stream  : out_bit, out_valid, out_ready
//   Status          : busy
// Modports:
//   slave  - the scheduler's own view
//   master - the surroundings (ACS unit, TBU, downstream sink)
// ---------------------------------------------------------------------------
interface tbu_sched_if;
   import tbu_sched_pkg::*;

   dec_word_t dec_in;
   logic      dec_valid;
   logic      dec_ready;

   logic      tbu_enable;
   logic      tbu_selection;
   dec_word_t tbu_d_in_0;
   dec_word_t tbu_d_in_1;
   logic      tbu_d_o;
   logic      tbu_wr_en;

   logic      out_bit;
   logic      out_valid;
   logic      out_ready;

   logic      busy;

   modport slave (
      input  dec_in, dec_valid, tbu_d_o, tbu_wr_en, out_ready,
      output dec_ready, tbu_enable, tbu_selection, tbu_d_in_0, tbu_d_in_1,
             out_bit, out_valid, busy
   );

   modport master (
      output dec_in, dec_valid, tbu_d_o, tbu_wr_en, out_ready,
      input  dec_ready, tbu_enable, tbu_selection, tbu_d_in_0, tbu_d_in_1,
             out_bit, out_valid, busy
   );

endinterface : tbu_sched_if

// File: rtl/tbu_reorder_buf.sv
// ---------------------------------------------------------------------------
// tbu_reorder_buf
// TB_LEN-bit reversal buffer. The traceback produces a block of decoded bits
// newest-first; the capture port places each bit at its forward-time index
// and the drain port replays the block oldest-first on a valid/ready stream.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   wr, wr_bit, wr_idx  capture one decoded bit at index wr_idx
//   mark_full         block complete, start draining from index 0
//   out_bit/out_valid/out_ready  drain stream
//   empty             no block held (free for the next session)
// ---------------------------------------------------------------------------
module tbu_reorder_buf #(
   parameter  int TB_LEN = 8,
   localparam int AW     = $clog2(TB_LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr,
   input  logic          wr_bit,
   input  logic [AW-1:0] wr_idx,
   input  logic          mark_full,
   output logic          out_bit,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          empty
);

   localparam logic [AW-1:0] LAST_IDX = AW'(TB_LEN - 1);

   logic [TB_LEN-1:0] bits;
   logic              full;
   logic [AW-1:0]     idx;

   // NOTE: data storage carries no reset; it is never observed until the
   // full flag (which is reset) says a complete block has been written.
   always_ff @(posedge clk) begin
      if (wr) begin
         bits[wr_idx] <= wr_bit;
      end
   end

   // NOTE: all clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full <= 1'b0;
         idx  <= '0;
      end else if (!full) begin
         idx <= '0;
         if (mark_full) begin
            full <= 1'b1;
         end
      end else if (out_ready) begin
         if (idx == LAST_IDX) begin
            full <= 1'b0;
            idx  <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   // Gated so stale or unknown storage never reaches the output.
   assign out_bit   = full & bits[idx];
   assign out_valid = full;
   assign empty     = !full;

endmodule : tbu_reorder_buf

// File: rtl/tbu_sched.sv
// ---------------------------------------------------------------------------
// tbu_sched
// Survivor-memory controller and traceback scheduler for the Viterbi decoder.
// ACS decision vectors are written into a 4-bank circular survivor memory of
// TB_LEN entries per bank. Once two banks are full and the output buffer is
// free, a session runs: a trace pass over the newer bank (rd_base+1) to
// settle the TBU state, then a decode pass over the older bank (rd_base)
// whose bits are captured, reversed and streamed out in forward order.
// Ports:
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   tbu_sched_if.slave: decision stream, TBU control/result,
//         decoded-bit stream, busy
// ---------------------------------------------------------------------------
module tbu_sched
   import tbu_sched_pkg::*;
#(
   parameter int TB_LEN = 8
) (
   input  logic        clk,
   input  logic        rst,
   tbu_sched_if.slave  bus
);

   localparam int AW = $clog2(TB_LEN);
   localparam int BW = $clog2(NUM_BANKS);
   localparam int CW = $clog2(NUM_BANKS + 1);

   localparam logic [AW-1:0] LAST_ADDR = AW'(TB_LEN - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(NUM_BANKS);
   localparam logic [CW-1:0] CNT_START = CW'(2);

   sched_state_t  state, state_nxt;

   logic [BW-1:0] wr_bank;
   logic [AW-1:0] wr_addr;
   logic [BW-1:0] rd_base;
   logic [BW-1:0] trace_bank;
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] full_cnt;
   logic [AW-1:0] cap_cnt;
   logic [AW-1:0] cap_idx;

   logic          wr_fire;
   logic          bank_done;
   logic          bank_release;
   logic          cap_fire;
   logic          mark_full;
   logic          buf_empty;

   dec_word_t     mem [NUM_BANKS*TB_LEN];
   dec_word_t     trace_word;
   dec_word_t     decode_word;

   // ------------------------------------------------------------------
   // Write side
   // ------------------------------------------------------------------
   // With every bank full the write bank aliases the decode bank, so the
   // stream is stalled until a session releases a bank.
   assign bus.dec_ready = (full_cnt != CNT_FULL);
   assign wr_fire       = bus.dec_valid && bus.dec_ready;
   assign bank_done     = wr_fire && (wr_addr == LAST_ADDR);

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[{wr_bank, wr_addr}] <= bus.dec_in;
      end
   end

   // TB_LEN and NUM_BANKS are powers of two, so both pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_bank <= '0;
         wr_addr <= '0;
      end else if (wr_fire) begin
         wr_addr <= wr_addr + 1'b1;
         if (bank_done) begin
            wr_bank <= wr_bank + 1'b1;
         end
      end
   end

   // Bank accounting; a completion and a release in the same cycle cancel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_cnt <= '0;
         rd_base  <= '0;
      end else begin
         if (bank_release) begin
            rd_base <= rd_base + 1'b1;
         end
         unique case ({bank_done, bank_release})
            2'b10:   full_cnt <= full_cnt + 1'b1;
            2'b01:   full_cnt <= full_cnt - 1'b1;
            default: full_cnt <= full_cnt;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Session FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt         = state;
      bus.tbu_enable    = 1'b0;
      bus.tbu_selection = 1'b0;
      bank_release      = 1'b0;
      mark_full         = 1'b0;
      unique case (state)
         IDLE: begin
            // Holding enable low here clears the TBU state between sessions.
            if ((full_cnt >= CNT_START) && buf_empty) begin
               state_nxt = TRACE;
            end
         end
         TRACE: begin
            bus.tbu_enable = 1'b1;
            if (rd_addr == '0) begin
               state_nxt = DECODE;
            end
         end
         DECODE: begin
            // Enable stays high across TRACE->DECODE so the settled
            // TBU state carries into the decode pass.
            bus.tbu_enable    = 1'b1;
            bus.tbu_selection = 1'b1;
            if (rd_addr == '0) begin
               state_nxt = TAIL;
            end
         end
         TAIL: begin
            // The TBU result is registered, so its last bit arrives here.
            bank_release = 1'b1;
            mark_full    = 1'b1;
            state_nxt    = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.busy = (state != IDLE);

   // Read address runs TB_LEN-1 down to 0 in each pass; the wrap from 0 back
   // to TB_LEN-1 reloads it for the next pass with no extra logic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_addr <= LAST_ADDR;
      end else if ((state == TRACE) || (state == DECODE)) begin
         rd_addr <= rd_addr - 1'b1;
      end
   end

   assign trace_bank  = rd_base + 1'b1;
   assign trace_word  = mem[{trace_bank, rd_addr}];
   assign decode_word = mem[{rd_base, rd_addr}];

   assign bus.tbu_d_in_0 = (state == TRACE)  ? trace_word  : '0;
   assign bus.tbu_d_in_1 = (state == DECODE) ? decode_word : '0;

   // ------------------------------------------------------------------
   // Capture of decoded bits into the reversal buffer
   // ------------------------------------------------------------------
   assign cap_fire = bus.tbu_wr_en && ((state == DECODE) || (state == TAIL));
   assign cap_idx  = LAST_ADDR - cap_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_cnt <= '0;
      end else if (state == IDLE) begin
         cap_cnt <= '0;
      end else if (cap_fire) begin
         cap_cnt <= cap_cnt + 1'b1;
      end
   end

   tbu_reorder_buf #(
      .TB_LEN (TB_LEN)
   ) u_reorder_buf (
      .clk       (clk),
      .rst       (rst),
      .wr        (cap_fire),
      .wr_bit    (bus.tbu_d_o),
      .wr_idx    (cap_idx),
      .mark_full (mark_full),
      .out_bit   (bus.out_bit),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .empty     (buf_empty)
   );

endmodule : tbu_sched

// File: tb/tb_tbu_sched.sv
// ---------------------------------------------------------------------------
// tb_tbu_sched
// Self-checking bench for tbu_sched. Contains a stand-in traceback unit
// (3-bit state, bit = word[state], state shifts the bit in from the top,
// registered d_o/wr_en, cleared while enable is low) and a scoreboard that
// derives expected decoded bits from the accepted decision words alone.
// ---------------------------------------------------------------------------
module tb_tbu_sched;
   import tbu_sched_pkg::*;

   localparam int TB_LEN = 8;

   logic clk;
   logic rst;

   tbu_sched_if bus ();

   tbu_sched #(.TB_LEN(TB_LEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- counters and check task ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- stand-in TBU ----------------
   logic [2:0] tbu_s;
   dec_word_t  tbu_word;
   logic       tbu_bit;

   assign tbu_word = bus.tbu_selection ? bus.tbu_d_in_1 : bus.tbu_d_in_0;
   assign tbu_bit  = tbu_word[tbu_s];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         tbu_s         <= '0;
         bus.tbu_d_o   <= 1'b0;
         bus.tbu_wr_en <= 1'b0;
      end else begin
         if (bus.tbu_enable) begin
            tbu_s       <= {tbu_bit, tbu_s[2:1]};
            bus.tbu_d_o <= tbu_bit;
         end else begin
            tbu_s       <= '0;
            bus.tbu_d_o <= 1'b0;
         end
         bus.tbu_wr_en <= bus.tbu_enable && bus.tbu_selection;
      end
   end

   // ---------------- scoreboard ----------------
   logic [7:0] words[$];
   bit         exp_q[$];
   bit         got_q[$];
   int         banks;
   int         sess;

   // Session j traces bank j+1 from state 0, then decodes bank j; decoded
   // bits come out newest-first and are emitted in reverse.
   task automatic push_session(input int j);
      logic [2:0]        s;
      logic [7:0]        w;
      logic              b;
      logic [TB_LEN-1:0] bits;
      s = '0;
      for (int a = TB_LEN - 1; a >= 0; a--) begin
         w = words[(j + 1) * TB_LEN + a];
         b = w[s];
         s = {b, s[2:1]};
      end
      for (int a = TB_LEN - 1; a >= 0; a--) begin
         w = words[j * TB_LEN + a];
         b = w[s];
         bits[TB_LEN - 1 - a] = b;
         s = {b, s[2:1]};
      end
      for (int k = TB_LEN - 1; k >= 0; k--) exp_q.push_back(bits[k]);
   endtask

   function automatic logic [7:0] got_vec();
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < TB_LEN && i < got_q.size(); i++) v[i] = got_q[i];
      return v;
   endfunction

   // ---------------- monitor (samples on the falling edge) ----------------
   initial begin : monitor
      int  en_run;
      int  sel_run;
      bit  hold_prev;
      bit  hold_bit;
      bit  b;
      en_run = 0; sel_run = 0; hold_prev = 0; hold_bit = 0;
      banks = 0; sess = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            words.delete(); exp_q.delete(); got_q.delete();
            banks = 0; sess = 0; en_run = 0; sel_run = 0; hold_prev = 0;
         end else begin
            check("dec_ready", bus.dec_ready, ((banks - sess) != NUM_BANKS));

            if (!bus.tbu_enable)
               check("idle_tbu_outs", {bus.tbu_selection, bus.tbu_d_in_0, bus.tbu_d_in_1}, 0);
            else if (bus.tbu_selection)
               check("d_in_0_in_decode", bus.tbu_d_in_0, 0);
            else
               check("d_in_1_in_trace", bus.tbu_d_in_1, 0);

            if (bus.tbu_enable) begin
               en_run++;
               if (bus.tbu_selection) sel_run++;
            end else if (en_run > 0) begin
               check("enable_run", en_run, 2 * TB_LEN);
               check("decode_run", sel_run, TB_LEN);
               sess++;
               en_run = 0;
               sel_run = 0;
            end

            if (hold_prev && bus.out_valid) check("out_stable", bus.out_bit, hold_bit);
            if (bus.out_valid && bus.out_ready) begin
               got_q.push_back(bus.out_bit);
               if (exp_q.size() == 0) begin
                  check("out_unexpected", exp_q.size(), 1);
               end else begin
                  b = exp_q.pop_front();
                  check("out_bit", bus.out_bit, b);
               end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            hold_bit  = bus.out_bit;

            if (bus.dec_valid && bus.dec_ready) begin
               words.push_back(bus.dec_in);
               if ((words.size() % TB_LEN) == 0) begin
                  banks++;
                  if (banks >= 2) push_session(banks - 2);
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic apply_reset();
      bus.dec_valid = 1'b0;
      bus.dec_in    = '0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
   endtask

   // Called and returns at posedge+1; holds one word until it is accepted.
   task automatic put_word(input logic [7:0] w, input int gap);
      int n;
      n = 0;
      bus.dec_in    = w;
      bus.dec_valid = 1'b1;
      while (!bus.dec_ready && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 500) check("put_word_timeout", bus.dec_ready, 1);
      @(posedge clk); #1;
      bus.dec_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.busy || bus.out_valid) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_pending"}, exp_q.size(), 0);
      check({tag, "_busy"}, bus.busy, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dec_ready"}, bus.dec_ready, 1);
      check({tag, "_enable"}, bus.tbu_enable, 0);
      check({tag, "_selection"}, bus.tbu_selection, 0);
      check({tag, "_d_in_0"}, bus.tbu_d_in_0, 0);
      check({tag, "_d_in_1"}, bus.tbu_d_in_1, 0);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_out_bit"}, bus.out_bit, 0);
      check({tag, "_busy"}, bus.busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   bit rnd_done;

   // ---------------- test sequence ----------------
   initial begin : stim
      int n;
      int acc;
      int stall_at;
      logic [7:0] w;

      rst = 1'b0;
      bus.dec_in    = '0;
      bus.dec_valid = 1'b0;
      bus.out_ready = 1'b1;
      #12;
      check_reset_outputs("reset");
      apply_reset();

      // 1: all-ones, single session, latency from second bank completion
      for (int i = 0; i < 2 * TB_LEN; i++) put_word(8'hFF, 0);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("t1_latency", n, 2 * TB_LEN + 2);
      wait_idle("t1");
      check("t1_bits", got_vec(), 8'hFF);
      check("t1_count", got_q.size(), TB_LEN);
      check("t1_sessions", sess, 1);
      check("t1_dec_ready", bus.dec_ready, 1);

      // 2: all-zeros
      apply_reset();
      for (int i = 0; i < 2 * TB_LEN; i++) put_word(8'h00, 0);
      wait_idle("t2");
      check("t2_bits", got_vec(), 8'h00);
      check("t2_count", got_q.size(), TB_LEN);

      // 3: single set decision at the newest entry of the decode bank
      apply_reset();
      for (int i = 0; i < 2 * TB_LEN; i++) put_word((i == TB_LEN - 1) ? 8'h01 : 8'h00, 0);
      wait_idle("t3");
      check("t3_bits", got_vec(), 8'h80);

      // 4: backpressure, 48 words offered back-to-back with out_ready low
      apply_reset();
      bus.out_ready = 1'b0;
      acc = 0;
      stall_at = -1;
      for (int c = 0; c < 150; c++) begin
         if (acc < 48) begin
            bus.dec_valid = 1'b1;
            bus.dec_in    = 8'($urandom);
         end else begin
            bus.dec_valid = 1'b0;
         end
         if (bus.dec_valid && !bus.dec_ready && stall_at < 0) stall_at = acc;
         if (bus.dec_valid && bus.dec_ready) acc++;
         @(posedge clk); #1;
      end
      check("t4_first_stall", stall_at, 4 * TB_LEN);
      check("t4_accepted", acc, (NUM_BANKS + 1) * TB_LEN);
      check("t4_dec_ready", bus.dec_ready, 0);
      check("t4_out_valid", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      n = 0;
      while (acc < 48 && n < 400) begin
         if (bus.dec_ready) acc++;
         bus.dec_in = bus.dec_ready ? bus.dec_in : 8'($urandom);
         @(posedge clk); #1;
         if (acc < 48) bus.dec_in = 8'($urandom);
         n++;
      end
      bus.dec_valid = 1'b0;
      check("t4_all_accepted", acc, 48);
      wait_idle("t4");
      check("t4_sessions", sess, 5);
      check("t4_count", got_q.size(), 5 * TB_LEN);

      // 5: reset during DECODE cycle 3, then all-ones again
      apply_reset();
      for (int i = 0; i < 2 * TB_LEN; i++) put_word(8'hFF, 0);
      n = 0;
      while (!bus.tbu_selection && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("t5_pre_busy", bus.busy, 1);
      check("t5_pre_selection", bus.tbu_selection, 1);
      rst = 1'b0;
      #1;
      check_reset_outputs("t5_async");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2 * TB_LEN; i++) put_word(8'hFF, 0);
      wait_idle("t5");
      check("t5_bits", got_vec(), 8'hFF);
      check("t5_sessions", sess, 1);

      // 6: random words, one accept every 3rd cycle
      apply_reset();
      for (int i = 0; i < 3 * TB_LEN; i++) begin
         w = 8'($urandom);
         put_word(w, 2);
      end
      wait_idle("t6");
      check("t6_sessions", sess, 2);
      check("t6_count", got_q.size(), 2 * TB_LEN);

      // 7: random words, random gaps, random downstream backpressure
      apply_reset();
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 10 * TB_LEN; i++) put_word(8'($urandom), $urandom_range(0, 2));
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               bus.out_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_idle("t7");
      check("t7_sessions", sess, 9);
      check("t7_count", got_q.size(), 9 * TB_LEN);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_tbu_sched
